// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution sequencer.
// Provides FSM states, branch op / condition codes and link offset.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EVAL     = 2'b01,
        RESOLVE  = 2'b10,
        REDIRECT = 2'b11
    } br_state_e;

    localparam logic [1:0] BR_OP_COND = 2'b00;
    localparam logic [1:0] BR_OP_JUMP = 2'b01;
    localparam logic [1:0] BR_OP_CALL = 2'b10;
    localparam logic [1:0] BR_OP_RET  = 2'b11;

    localparam logic [1:0] COND_GT    = 2'b00;
    localparam logic [1:0] COND_LT    = 2'b01;
    localparam logic [1:0] COND_EQ    = 2'b10;
    localparam logic [1:0] COND_NEVER = 2'b11;

    localparam int unsigned LINK_OFFSET = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Signed test of a register value against zero.
// Ports: opcond (GT/LT/EQ/NEVER), a (operand) -> y (condition holds).
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      opcond,
    input  logic [XLEN-1:0] a,
    output logic            y
);

    logic neg;
    logic zero;

    assign neg  = a[XLEN-1];
    assign zero = (a == '0);

    always_comb begin
        y = 1'b0;
        unique case (opcond)
            COND_GT:    y = !neg && !zero;
            COND_LT:    y = neg;
            COND_EQ:    y = zero;
            COND_NEVER: y = 1'b0;
            default:    y = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: accepts a branch, evaluates it, redirects fetch.
// Ports: br_* request, kill flush, redir_* to fetch, link_*, done/taken, stats.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_op,
    input  logic [1:0]       br_cond,
    input  logic [XLEN-1:0]  br_rs,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_off,
    input  logic             kill,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             link_we,
    output logic [XLEN-1:0]  link_data,
    output logic             done,
    output logic             taken,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken
);

    br_state_e        state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       cond_q, cond_d;
    logic [XLEN-1:0]  rs_q, rs_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  off_q, off_d;
    logic             outcome_q, outcome_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             redir_valid_q, redir_valid_d;
    logic             link_we_q, link_we_d;
    logic [XLEN-1:0]  link_data_q, link_data_d;
    logic             done_q, done_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] stat_br_q, stat_br_d;
    logic [CNT_W-1:0] stat_tk_q, stat_tk_d;

    logic             cond_y;
    logic [XLEN-1:0]  tgt;
    logic [CNT_W-1:0] br_inc;
    logic [CNT_W-1:0] tk_inc;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .opcond (cond_q),
        .a      (rs_q),
        .y      (cond_y)
    );

    assign br_ready = (state_q == IDLE) && !kill;

    // Saturating increments: hold once all-ones is reached.
    assign br_inc = (stat_br_q == '1) ? stat_br_q
                                      : stat_br_q + CNT_W'(1);
    assign tk_inc = (stat_tk_q == '1) ? stat_tk_q
                                      : stat_tk_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cond_d        = cond_q;
        rs_d          = rs_q;
        pc_d          = pc_q;
        off_d         = off_q;
        outcome_d     = outcome_q;
        target_d      = target_q;
        redir_valid_d = redir_valid_q;
        link_we_d     = 1'b0;
        link_data_d   = link_data_q;
        done_d        = 1'b0;
        taken_d       = 1'b0;
        stat_br_d     = stat_br_q;
        stat_tk_d     = stat_tk_q;
        tgt           = (op_q == BR_OP_RET) ? rs_q : pc_q + off_q;

        unique case (state_q)
            IDLE: begin
                if (br_valid && br_ready) begin
                    op_d    = br_op;
                    cond_d  = br_cond;
                    rs_d    = br_rs;
                    pc_d    = br_pc;
                    off_d   = br_off;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                outcome_d   = (op_q == BR_OP_COND) ? cond_y : 1'b1;
                target_d    = tgt & ~XLEN'(3);
                // Strobe is registered so it lands in RESOLVE.
                link_we_d   = (op_q == BR_OP_CALL);
                link_data_d = pc_q + XLEN'(LINK_OFFSET);
                state_d     = RESOLVE;
            end
            RESOLVE: begin
                if (outcome_q) begin
                    redir_valid_d = 1'b1;
                    state_d       = REDIRECT;
                end else begin
                    done_d    = 1'b1;
                    stat_br_d = br_inc;
                    state_d   = IDLE;
                end
            end
            REDIRECT: begin
                if (redir_ready) begin
                    redir_valid_d = 1'b0;
                    done_d        = 1'b1;
                    taken_d       = 1'b1;
                    stat_br_d     = br_inc;
                    stat_tk_d     = tk_inc;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush overrides any pending retirement or redirect.
        if (kill && state_q != IDLE) begin
            state_d       = IDLE;
            redir_valid_d = 1'b0;
            link_we_d     = 1'b0;
            done_d        = 1'b0;
            taken_d       = 1'b0;
            stat_br_d     = stat_br_q;
            stat_tk_d     = stat_tk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= '0;
            cond_q        <= '0;
            rs_q          <= '0;
            pc_q          <= '0;
            off_q         <= '0;
            outcome_q     <= 1'b0;
            target_q      <= '0;
            redir_valid_q <= 1'b0;
            link_we_q     <= 1'b0;
            link_data_q   <= '0;
            done_q        <= 1'b0;
            taken_q       <= 1'b0;
            stat_br_q     <= '0;
            stat_tk_q     <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cond_q        <= cond_d;
            rs_q          <= rs_d;
            pc_q          <= pc_d;
            off_q         <= off_d;
            outcome_q     <= outcome_d;
            target_q      <= target_d;
            redir_valid_q <= redir_valid_d;
            link_we_q     <= link_we_d;
            link_data_q   <= link_data_d;
            done_q        <= done_d;
            taken_q       <= taken_d;
            stat_br_q     <= stat_br_d;
            stat_tk_q     <= stat_tk_d;
        end
    end

    assign redir_valid   = redir_valid_q;
    assign redir_pc      = target_q;
    assign link_we       = link_we_q;
    assign link_data     = link_data_q;
    assign done          = done_q;
    assign taken         = taken_q;
    assign stat_branches = stat_br_q;
    assign stat_taken    = stat_tk_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl (plus a CNT_W=2 copy for saturation).
// Driver pushes expected outcomes; a negedge monitor pops and compares.
module tb_branch_resolve_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_op = '0;
    logic [1:0]  br_cond = '0;
    logic [31:0] br_rs = '0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_off = '0;
    logic        kill = 1'b0;
    logic        redir_ready = 1'b0;

    logic        br_ready, redir_valid, link_we, done, taken;
    logic [31:0] redir_pc, link_data;
    logic [15:0] stat_branches, stat_taken;

    logic        s_br_ready, s_redir_valid, s_link_we, s_done, s_taken;
    logic [31:0] s_redir_pc, s_link_data;
    logic [1:0]  s_stat_branches, s_stat_taken;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_op(br_op), .br_cond(br_cond), .br_rs(br_rs), .br_pc(br_pc),
        .br_off(br_off), .kill(kill), .redir_valid(redir_valid),
        .redir_ready(redir_ready), .redir_pc(redir_pc), .link_we(link_we),
        .link_data(link_data), .done(done), .taken(taken),
        .stat_branches(stat_branches), .stat_taken(stat_taken)
    );

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(s_br_ready),
        .br_op(br_op), .br_cond(br_cond), .br_rs(br_rs), .br_pc(br_pc),
        .br_off(br_off), .kill(kill), .redir_valid(s_redir_valid),
        .redir_ready(redir_ready), .redir_pc(s_redir_pc), .link_we(s_link_we),
        .link_data(s_link_data), .done(s_done), .taken(s_taken),
        .stat_branches(s_stat_branches), .stat_taken(s_stat_taken)
    );

    typedef struct {
        logic [1:0]  op;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] lnk;
        int          t;
        bit          seen_rv;
        bit          seen_lw;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_br = 0;
    int   n_tk = 0;
    int   hs_cyc = -100;
    int   rr_low = 0;
    bit   rr_all1 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // Reference: what a branch should do, straight from the rules.
    function automatic exp_t model(input logic [1:0] op, input logic [1:0] cond,
                                   input logic [31:0] rs, input logic [31:0] pc,
                                   input logic [31:0] off);
        exp_t e;
        e.op = op;
        if (op != BR_OP_COND) e.tk = 1'b1;
        else if (cond == COND_GT) e.tk = ($signed(rs) > 0);
        else if (cond == COND_LT) e.tk = ($signed(rs) < 0);
        else if (cond == COND_EQ) e.tk = (rs == 32'd0);
        else e.tk = 1'b0;
        e.tgt = ((op == BR_OP_RET) ? rs : pc + off) & 32'hFFFF_FFFC;
        e.lnk = pc + 32'd4;
        e.t = 0;
        e.seen_rv = 1'b0;
        e.seen_lw = 1'b0;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (redir_valid) begin
                if (sb.size() == 0) begin
                    chk("redir_unexpected", 64'(redir_valid), 64'd0);
                end else begin
                    chk("redir_pc", 64'(redir_pc), 64'(sb[0].tgt));
                    chk("redir_is_taken", 64'(sb[0].tk), 64'd1);
                    chk("ready_while_redir", 64'(br_ready), 64'd0);
                    if (!sb[0].seen_rv) begin
                        chk("redir_latency", 64'(cyc), 64'(sb[0].t + 3));
                        sb[0].seen_rv = 1'b1;
                    end
                    if (redir_ready && !kill) hs_cyc = cyc;
                end
            end
            if (link_we) begin
                if (sb.size() == 0) begin
                    chk("link_unexpected", 64'(link_we), 64'd0);
                end else begin
                    chk("link_data", 64'(link_data), 64'(sb[0].lnk));
                    chk("link_op", 64'(sb[0].op), 64'(BR_OP_CALL));
                    chk("link_latency", 64'(cyc), 64'(sb[0].t + 2));
                    sb[0].seen_lw = 1'b1;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("taken", 64'(taken), 64'(e.tk));
                    if (e.tk) begin
                        chk("done_after_hs", 64'(cyc), 64'(hs_cyc + 1));
                        chk("ready_at_done", 64'(br_ready || kill), 64'd1);
                    end else begin
                        chk("done_latency", 64'(cyc), 64'(e.t + 3));
                    end
                    if (e.op == BR_OP_CALL)
                        chk("link_seen", 64'(e.seen_lw), 64'd1);
                    n_br++;
                    if (e.tk) n_tk++;
                    chk("stat_branches", 64'(stat_branches), 64'(sat(n_br, 65535)));
                    chk("stat_taken", 64'(stat_taken), 64'(sat(n_tk, 65535)));
                    chk("s_stat_branches", 64'(s_stat_branches), 64'(sat(n_br, 3)));
                    chk("s_stat_taken", 64'(s_stat_taken), 64'(sat(n_tk, 3)));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rr_low > 0) begin
            redir_ready = 1'b0;
            rr_low--;
        end else begin
            redir_ready = rr_all1 ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    endtask

    // km: 0 plain, 1 kill in EVAL, 2 kill in REDIRECT, 3 kill with
    // redir_ready high, 4 stall redirect, 5 hold redirect (return at T+1)
    task automatic issue(input logic [1:0] op, input logic [1:0] cond,
                         input logic [31:0] rs, input logic [31:0] pc,
                         input logic [31:0] off, input int km);
        exp_t e;
        int   n = 0;
        while (!br_ready && n < 100) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(br_ready), 64'd1);
        if (!br_ready) return;
        br_valid = 1'b1;
        br_op = op;
        br_cond = cond;
        br_rs = rs;
        br_pc = pc;
        br_off = off;
        e = model(op, cond, rs, pc, off);
        e.t = cyc;
        sb.push_back(e);
        if (km == 4) rr_low = 8;
        if (km == 2 || km == 3 || km == 5) rr_low = 50;
        step();
        br_valid = 1'b0;
        br_rs = $urandom();
        br_pc = $urandom();
        br_off = $urandom();
        br_op = 2'($urandom_range(0, 3));
        if (km == 1) begin
            kill = 1'b1;
            step();
            kill = 1'b0;
            e = sb.pop_back();
            @(negedge clk);
            chk("kill_eval_done", 64'(done), 64'd0);
            chk("kill_eval_link", 64'(link_we), 64'd0);
            chk("kill_eval_ready", 64'(br_ready), 64'd1);
        end else if (km == 2 || km == 3) begin
            step();
            step();
            chk("redir_up", 64'(redir_valid), 64'd1);
            kill = 1'b1;
            if (km == 3) redir_ready = 1'b1;
            step();
            kill = 1'b0;
            rr_low = 0;
            e = sb.pop_back();
            @(negedge clk);
            chk("kill_redir_valid", 64'(redir_valid), 64'd0);
            chk("kill_redir_done", 64'(done), 64'd0);
            chk("kill_stat", 64'(stat_branches), 64'(sat(n_br, 65535)));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_redir_valid"}, 64'(redir_valid), 64'd0);
        chk({tag, "_redir_pc"}, 64'(redir_pc), 64'd0);
        chk({tag, "_link_we"}, 64'(link_we), 64'd0);
        chk({tag, "_link_data"}, 64'(link_data), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_taken"}, 64'(taken), 64'd0);
        chk({tag, "_stat_br"}, 64'(stat_branches), 64'd0);
        chk({tag, "_stat_tk"}, 64'(stat_taken), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op, cond;
        logic [31:0] rs, pc, off;
        exp_t        e;
        int          km, r;

        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_ready", 64'(br_ready), 64'd1);

        rr_all1 = 1'b1;
        issue(BR_OP_COND, COND_GT, 32'd5, 32'h100, 32'h20, 0);
        issue(BR_OP_COND, COND_LT, 32'd5, 32'h100, 32'h20, 0);
        issue(BR_OP_CALL, COND_NEVER, 32'd0, 32'h200, 32'h40, 4);
        issue(BR_OP_JUMP, COND_GT, 32'd0, 32'hFFFF_FFF0, 32'h20, 0);
        issue(BR_OP_COND, COND_LT, 32'h8000_0000, 32'h300, 32'h8, 0);
        issue(BR_OP_RET, COND_EQ, 32'h1237, 32'h400, 32'h10, 0);
        issue(BR_OP_COND, COND_NEVER, 32'd5, 32'h500, 32'h10, 0);
        issue(BR_OP_COND, COND_EQ, 32'd0, 32'h600, 32'hFFFF_FFF0, 0);
        issue(BR_OP_JUMP, COND_GT, 32'd0, 32'h700, 32'h40, 2);
        issue(BR_OP_CALL, COND_GT, 32'd0, 32'h800, 32'h40, 3);
        issue(BR_OP_COND, COND_EQ, 32'd0, 32'h900, 32'h40, 1);
        drain();

        rr_all1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            cond = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            rs = (r == 0) ? 32'd0 : (r == 1) ? 32'h8000_0000 : $urandom();
            pc = $urandom();
            off = $urandom();
            e = model(op, cond, rs, pc, off);
            r = $urandom_range(0, 7);
            if (r == 0) km = 1;
            else if (e.tk && r == 1) km = 2;
            else if (e.tk && r == 2) km = 3;
            else km = 0;
            issue(op, cond, rs, pc, off, km);
        end
        drain();

        rr_all1 = 1'b1;
        issue(BR_OP_JUMP, COND_GT, 32'd0, 32'h1000, 32'h40, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_eval");
        sb.delete();
        n_br = 0;
        n_tk = 0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(BR_OP_JUMP, COND_GT, 32'd0, 32'h2000, 32'h40, 5);
        step();
        step();
        chk("pre_rst_redir", 64'(redir_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_redir");
        sb.delete();
        n_br = 0;
        n_tk = 0;
        rr_low = 0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(BR_OP_COND, COND_GT, 32'd1, 32'h3000, 32'h10, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
